// File: rtl/msg_sched_if.sv
// Handshake bundle between the message loader, the schedule controller and the round engine.
interface msg_sched_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 6;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              w_valid;
  logic              w_ready;
  logic [WORD_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;

  // Driver side: loader producing words, round engine consuming schedule words.
  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, w_word, w_idx
  );

  // Controller side.
  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, w_word, w_idx
  );
endinterface

// File: rtl/msg_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads 16 words, then streams W[0..NUM_ROUNDS-1].
module msg_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  msg_sched_if.slave  bus,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned WIN_LEN = 16;
  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W-1:0] FIRST_CALC_T = IDX_W'(WIN_LEN);

  // Round counts outside 16..64 cannot be represented by the window/index widths.
  if (NUM_ROUNDS < 16 || NUM_ROUNDS > 64) begin : g_bad_rounds
    $error("msg_sched_ctrl: NUM_ROUNDS must be in 16..64");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_win [WIN_LEN];
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_t;
  logic              r_in_ready;
  logic              r_w_valid;
  logic              r_busy;
  logic              r_done;

  logic [WORD_W-1:0] w_sum;
  logic [WORD_W-1:0] w_word;

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next schedule word from the sliding window (oldest word in slot 0).
  always_comb begin
    w_sum = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];
  end

  // Presented word: raw window for the first 16 rounds, expansion afterwards.
  always_comb begin
    w_word = '0;
    if (r_w_valid) begin
      if (r_t < FIRST_CALC_T) begin
        w_word = r_win[r_t[CNT_W-1:0]];
      end else begin
        w_word = w_sum;
      end
    end
  end

  // Control FSM with registered handshake/status outputs and window update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_t        <= '0;
      r_in_ready <= 1'b0;
      r_w_valid  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < WIN_LEN; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse belongs to the finished block.
          if (start && !r_done) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.in_valid && r_in_ready) begin
            r_win[r_cnt] <= bus.in_word;
            r_cnt        <= CNT_W'(r_cnt + 1'b1);
            if (r_cnt == CNT_W'(WIN_LEN - 1)) begin
              r_state    <= S_EMIT;
              r_in_ready <= 1'b0;
              r_w_valid  <= 1'b1;
              r_t        <= '0;
            end
          end
        end
        S_EMIT: begin
          if (bus.w_ready && r_w_valid) begin
            if (r_t >= FIRST_CALC_T) begin
              for (int i = 0; i < WIN_LEN - 1; i++) begin
                r_win[i] <= r_win[i+1];
              end
              r_win[WIN_LEN-1] <= w_word;
            end
            if (r_t == LAST_T) begin
              r_state   <= S_IDLE;
              r_w_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_t       <= '0;
            end else begin
              r_t <= IDX_W'(r_t + 1'b1);
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_w_valid  <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.w_valid  = r_w_valid;
  assign bus.w_word   = w_word;
  assign bus.w_idx    = r_t;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_msg_sched_ctrl.sv
// Randomized self-checking bench for msg_sched_ctrl against an array-based SHA-256 schedule model.
module tb_msg_sched_ctrl;

  localparam int NR = 64;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic start16;
  logic busy16;
  logic done16;

  msg_sched_if bus ();
  msg_sched_if b16 ();

  msg_sched_ctrl #(.NUM_ROUNDS(NR)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  msg_sched_ctrl #(.NUM_ROUNDS(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .bus   (b16.slave),
    .busy  (busy16),
    .done  (done16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] abc_k [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule from the textbook recurrence over the full W array.
  task automatic compute_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_ref();
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    compute_ref();
  endtask

  // Drives one block through the 64-round DUT, checking every presented word.
  task automatic run_block(input int gap_pct, input int stall_pct, input bit poke,
                           input int abort_t, input bit abc);
    int  loaded = 0;
    int  t      = 0;
    int  cyc    = 0;
    bit  fin    = 1'b0;
    bit  last   = 1'b0;
    bit  in_emit;
    @(negedge clk);
    start = 1'b1;
    bus.in_valid = 1'b0;
    bus.w_ready  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!fin && cyc < 4000) begin
      if (last) begin
        check("done_pulse", 32'(done), 32'd1);
        check("w_valid_at_done", 32'(bus.w_valid), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        if (gap_pct == 0 && stall_pct == 0) check("latency", 32'(cyc + 1), 32'(1 + 16 + NR));
        start = 1'b1;
        bus.in_valid = 1'b0;
        bus.w_ready  = 1'b0;
        fin = 1'b1;
      end else begin
        in_emit = (loaded == 16);
        check("done_low", 32'(done), 32'd0);
        check("w_valid", 32'(bus.w_valid), 32'(in_emit));
        start = poke ? 1'($urandom % 2) : 1'b0;
        if (!in_emit) begin
          check("in_ready_load", 32'(bus.in_ready), 32'd1);
          bus.in_valid = (($urandom % 100) >= 32'(gap_pct));
          bus.in_word  = bus.in_valid ? blk[loaded] : $urandom;
          if (bus.in_valid && bus.in_ready) loaded++;
          bus.w_ready = 1'($urandom % 2);
        end else begin
          check("in_ready_emit", 32'(bus.in_ready), 32'd0);
          bus.in_valid = poke ? 1'($urandom % 2) : 1'b0;
          bus.in_word  = $urandom;
        end
        if (bus.w_valid) begin
          if (t == abort_t) begin
            rst_n = 1'b0;
            #1;
            check("abort_w_valid", 32'(bus.w_valid), 32'd0);
            check("abort_in_ready", 32'(bus.in_ready), 32'd0);
            check("abort_w_word", bus.w_word, 32'd0);
            check("abort_w_idx", 32'(bus.w_idx), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            start = 1'b0;
            bus.in_valid = 1'b0;
            bus.w_ready  = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("post_abort_busy", 32'(busy), 32'd0);
            return;
          end
          check("w_idx", 32'(bus.w_idx), 32'(t));
          check("w_word", bus.w_word, exp_w[t]);
          if (abc && t >= 16 && t < 20) check("abc_const", bus.w_word, abc_k[t-16]);
          bus.w_ready = (($urandom % 100) >= 32'(stall_pct));
          if (bus.w_ready) begin
            t++;
            if (t == NR) last = 1'b1;
          end
        end
      end
      cyc++;
      @(negedge clk);
    end
    if (!fin) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      // start raised during the done cycle must not launch another block
      check("start_at_done_ignored", 32'(busy), 32'd0);
      check("done_single_pulse", 32'(done), 32'd0);
    end
    start = 1'b0;
  endtask

  // Short-schedule instance: words 0..15 only, then done and back to idle.
  task automatic run16();
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b16.in_valid = 1'b1;
      b16.in_word  = 32'(i);
      @(negedge clk);
    end
    b16.in_valid = 1'b0;
    b16.w_ready  = 1'b1;
    for (int t = 0; t < 16; t++) begin
      check("r16_w_valid", 32'(b16.w_valid), 32'd1);
      check("r16_w_idx", 32'(b16.w_idx), 32'(t));
      check("r16_w_word", b16.w_word, 32'(t));
      @(negedge clk);
    end
    check("r16_done", 32'(done16), 32'd1);
    check("r16_w_valid_end", 32'(b16.w_valid), 32'd0);
    b16.w_ready = 1'b0;
    @(negedge clk);
    check("r16_idle_busy", 32'(busy16), 32'd0);
    check("r16_done_low", 32'(done16), 32'd0);
  endtask

  initial begin
    abc_k[0] = 32'h61626380;
    abc_k[1] = 32'h000F0000;
    abc_k[2] = 32'h7DA86405;
    abc_k[3] = 32'h600003C6;
    rst_n = 1'b0;
    start = 1'b0;
    start16 = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.w_ready  = 1'b0;
    b16.in_valid = 1'b0;
    b16.in_word  = '0;
    b16.w_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_w_valid", 32'(bus.w_valid), 32'd0);
    check("rst_w_word", bus.w_word, 32'd0);
    check("rst_w_idx", 32'(bus.w_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // in_valid while idle without start is not consumed
    bus.in_valid = 1'b1;
    bus.in_word  = 32'hDEADBEEF;
    repeat (5) begin
      @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    bus.in_valid = 1'b0;

    load_abc();
    run_block(0, 0, 1'b0, -1, 1'b1);
    run_block(30, 40, 1'b0, -1, 1'b1);
    run_block(20, 20, 1'b1, -1, 1'b1);
    run_block(0, 20, 1'b0, 30, 1'b1);
    run_block(0, 0, 1'b0, -1, 1'b1);

    for (int k = 0; k < 3; k++) begin
      load_random();
      run_block(int'($urandom % 50), int'($urandom % 50), 1'($urandom % 2), -1, 1'b0);
    end

    run16();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_sched_ctrl.md
Name: msg_sched_ctrl

Overview:
- Sequences the SHA-256 message-schedule datapath: accepts one 512-bit block as 16 serial 32-bit words, then streams W[0]..W[NUM_ROUNDS-1] to the compression round engine, one word per handshake.
- Holds a 16-word sliding window and instantiates the sigma0 and sigma1 small-sigma functions.
- Sits between the block padder/loader and the round controller.
- Applies backpressure on both sides and signals completion per block.

Parameters:
- NUM_ROUNDS, 64, number of schedule words emitted per block. Legal range 16..64; other values are a synthesis error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a block. Honoured only in IDLE.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  controller accepts in_word this cycle.
- in_word  in  32  message word, W[0] first, big-endian word order.
- w_valid  out  1  w_word/w_idx are valid.
- w_ready  in  1  consumer accepts w_word this cycle.
- w_word  out  32  schedule word W[t].
- w_idx  out  6  t of the presented word.
- busy  out  1  high in LOAD or EMIT.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=0, w_valid=0, w_word=0, w_idx=0, busy=0, done=0. Window registers and counters are cleared to 0.
- Reset mid-operation aborts the block immediately. After release the controller is in IDLE with no partial output.
- States are IDLE, LOAD, EMIT.
- IDLE:
  - All handshakes are deasserted; in_valid is ignored.
  - start=1 moves to LOAD next cycle and clears the load count.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready writes in_word to win[cnt] and increments cnt.
  - On the 16th accept, go to EMIT with t=0. The first w_valid appears the cycle after the 16th accept.
- EMIT:
  - w_valid=1 and w_idx=t.
  - For t<16: w_word=win[t] and the window is unchanged.
  - For t>=16, window content is win[0]=W[t-16] .. win[15]=W[t-1]. w_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], computed mod 2^32.
  - w_word is combinational from registered state and stable while w_valid=1 and w_ready=0.
  - On w_valid&w_ready: if t>=16, shift the window down by one and write w_word into win[15]; then t increments.
  - When the accepted word has t=NUM_ROUNDS-1: done=1 for one cycle and the next state is IDLE (w_valid=0 that cycle).
- start asserted in LOAD or EMIT is ignored, with no restart.
- start in the same cycle that done pulses is ignored. A new start is needed from IDLE.
- Backpressure:
  - in_valid=0 or w_ready=0 stalls indefinitely with no state change.
  - No word is dropped or duplicated.
- Throughput: one word per cycle on each interface when unstalled.
- Block latency with continuous handshakes: 1 (start) + 16 (load) + NUM_ROUNDS cycles.
- busy=1 exactly when state is LOAD or EMIT.

Test Plan:
1. Reset, then start, load the "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) with w_ready=1. Required: W0..W15 echoed in order, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; w_idx runs 0..63; done pulses once, one cycle after W63 is accepted.
2. Same block with w_ready toggled pseudo-randomly and in_valid gapped. Required: an identical W sequence, and w_word/w_idx held stable during every stall.
3. Assert start and in_valid during EMIT. Required: no restart, in_ready=0, W sequence unaffected.
4. Assert rst_n low at t=30 in EMIT. Required: all outputs go to reset values asynchronously; after release, a fresh block yields a correct full sequence.
5. With NUM_ROUNDS=16, load W0..W15=0x00000000..0x0000000F. Required: exactly those 16 words are output, then done, then IDLE.
6. Assert in_valid in IDLE without start. Required: in_ready=0 and no words are consumed.
